// File: rtl/race_control.sv
// rtl/race_control.sv - race sequencer: 3-2-1 countdown, checkpoint-gated lap detection,
// pause/resume and abort, driving the lap timer's start/stop/lap_finished inputs.
module race_control #(
  parameter int TICKS_PER_STEP = 65000000,
  parameter int LAPS           = 3,
  parameter int FIN_X0         = 400,
  parameter int FIN_X1         = 420,
  parameter int FIN_Y0         = 500,
  parameter int FIN_Y1         = 600,
  parameter int CP_X0          = 400,
  parameter int CP_X1          = 420,
  parameter int CP_Y0          = 100,
  parameter int CP_Y1          = 200
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        race_go,
  input  logic        pause_btn,
  input  logic        abort,
  input  logic [10:0] car_x,
  input  logic [10:0] car_y,
  input  logic        pos_valid,
  output logic        start,
  output logic        stop,
  output logic        lap_finished,
  output logic [1:0]  countdown,
  output logic        race_active,
  output logic [3:0]  lap_count,
  output logic        race_done
);

  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]  LAPS_L = 4'(LAPS);
  localparam logic [10:0] FX0 = 11'(FIN_X0), FX1 = 11'(FIN_X1);
  localparam logic [10:0] FY0 = 11'(FIN_Y0), FY1 = 11'(FIN_Y1);
  localparam logic [10:0] CX0 = 11'(CP_X0),  CX1 = 11'(CP_X1);
  localparam logic [10:0] CY0 = 11'(CP_Y0),  CY1 = 11'(CP_Y1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_RACE  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      countdown_q, countdown_d;
  logic [3:0]      lap_count_q, lap_count_d;
  logic            start_q, start_d, stop_q, stop_d, lap_finished_q, lap_finished_d;
  logic            race_active_q, race_active_d, race_done_q, race_done_d;
  logic            cp_seen_q, cp_seen_d, prev_in_fin_q, prev_in_fin_d;
  logic            pending_stop_q, pending_stop_d;

  logic       in_fin, in_cp, step_done, lap_hit;
  logic [3:0] lap_inc;

  assign in_fin = (car_x >= FX0) && (car_x <= FX1) && (car_y >= FY0) && (car_y <= FY1);
  assign in_cp  = (car_x >= CX0) && (car_x <= CX1) && (car_y >= CY0) && (car_y <= CY1);
  assign step_done = (tick_q == TICK_LAST);
  assign lap_inc   = (lap_count_q == 4'd15) ? 4'd15 : lap_count_q + 4'd1;
  // A crossing counts only on the rising edge into the finish zone after a checkpoint visit.
  assign lap_hit = (state_q == S_RACE) && !abort && !pending_stop_q && pos_valid &&
                   in_fin && !prev_in_fin_q && cp_seen_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      countdown_q    <= 2'd0;
      lap_count_q    <= 4'd0;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      lap_finished_q <= 1'b0;
      race_active_q  <= 1'b0;
      race_done_q    <= 1'b0;
      cp_seen_q      <= 1'b0;
      prev_in_fin_q  <= 1'b0;
      pending_stop_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      countdown_q    <= countdown_d;
      lap_count_q    <= lap_count_d;
      start_q        <= start_d;
      stop_q         <= stop_d;
      lap_finished_q <= lap_finished_d;
      race_active_q  <= race_active_d;
      race_done_q    <= race_done_d;
      cp_seen_q      <= cp_seen_d;
      prev_in_fin_q  <= prev_in_fin_d;
      pending_stop_q <= pending_stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    if (abort) begin
      state_d = S_IDLE;
      tick_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (race_go) begin
          state_d = S_COUNT;
          tick_d  = '0;
        end
        S_COUNT: if (step_done) begin
          tick_d = '0;
          if (countdown_q == 2'd1) state_d = S_RACE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        S_RACE: if (pending_stop_q) state_d = S_DONE;
                else if (pause_btn && !lap_hit) state_d = S_PAUSE;
        S_PAUSE: if (pause_btn) state_d = S_RACE;
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    start_d        = 1'b0;
    stop_d         = 1'b0;
    lap_finished_d = 1'b0;
    countdown_d    = countdown_q;
    lap_count_d    = lap_count_q;
    cp_seen_d      = cp_seen_q;
    prev_in_fin_d  = prev_in_fin_q;
    pending_stop_d = pending_stop_q;
    race_active_d  = (state_d == S_RACE);
    race_done_d    = (state_d == S_DONE);
    if (abort) begin
      countdown_d    = 2'd0;
      pending_stop_d = 1'b0;
      stop_d         = (state_q == S_RACE) || (state_q == S_PAUSE);
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (race_go) begin
          countdown_d = 2'd3;
          lap_count_d = 4'd0;
        end
        S_COUNT: if (step_done) begin
          if (countdown_q == 2'd1) begin
            countdown_d   = 2'd0;
            start_d       = 1'b1;
            cp_seen_d     = 1'b0;
            prev_in_fin_d = 1'b1;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
        S_RACE: if (pending_stop_q) begin
          stop_d         = 1'b1;
          pending_stop_d = 1'b0;
        end else begin
          if (pos_valid) begin
            if (lap_hit) begin
              lap_finished_d = 1'b1;
              lap_count_d    = lap_inc;
              cp_seen_d      = 1'b0;
              if (lap_inc == LAPS_L) pending_stop_d = 1'b1;
            end
            if (in_cp) cp_seen_d = 1'b1;
            prev_in_fin_d = in_fin;
          end
          if (pause_btn && !lap_hit) stop_d = 1'b1;
        end
        S_PAUSE: if (pause_btn) start_d = 1'b1;
        default: countdown_d = 2'd0;
      endcase
    end
  end

  assign start        = start_q;
  assign stop         = stop_q;
  assign lap_finished = lap_finished_q;
  assign countdown    = countdown_q;
  assign race_active  = race_active_q;
  assign lap_count    = lap_count_q;
  assign race_done    = race_done_q;

endmodule

// File: tb/tb_race_control.sv
// tb/tb_race_control.sv - scoreboard bench for race_control with short countdown steps and a 2-lap race.
module tb_race_control;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        race_go = 1'b0, pause_btn = 1'b0, abort = 1'b0, pos_valid = 1'b0;
  logic [10:0] car_x = '0, car_y = '0;
  logic        start, stop, lap_finished, race_active, race_done;
  logic [1:0]  countdown;
  logic [3:0]  lap_count;

  localparam int K_START = 1, K_STOP = 2, K_LAP = 4;

  typedef struct {
    string tag;
    int    kind;
    int    cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  race_control #(.TICKS_PER_STEP(4), .LAPS(2)) dut (
    .pclk(pclk), .rst(rst), .race_go(race_go), .pause_btn(pause_btn), .abort(abort),
    .car_x(car_x), .car_y(car_y), .pos_valid(pos_valid),
    .start(start), .stop(stop), .lap_finished(lap_finished), .countdown(countdown),
    .race_active(race_active), .lap_count(lap_count), .race_done(race_done)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input string tag, input int kind, input int at);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Each call presents the inputs for exactly one rising edge.
  task automatic drive(input logic go, input logic pb, input logic ab, input logic pv,
                       input logic [10:0] x, input logic [10:0] y);
    race_go = go; pause_btn = pb; abort = ab; pos_valid = pv; car_x = x; car_y = y;
    @(posedge pclk);
    #1;
    race_go = 1'b0; pause_btn = 1'b0; abort = 1'b0; pos_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
  endtask

  task automatic pos(input int x, input int y);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 11'(x), 11'(y));
  endtask

  function automatic int all_outs();
    return int'({start, stop, lap_finished, countdown, race_active, lap_count, race_done});
  endfunction

  // Pulse monitor: every pulse seen must match the head of the scoreboard in kind and cycle.
  always @(negedge pclk) begin
    int   kind;
    exp_t e;
    kind = int'({lap_finished, stop, start});
    if (kind != 0) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", kind * 100000 + cyc, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq(e.tag, kind * 100000 + cyc, e.kind * 100000 + e.cyc);
      end
    end
  end

  task automatic run_countdown(input string tag);
    expect_pulse(tag, K_START, cyc + 13);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    for (int j = 0; j < 12; j++) begin
      check_eq({tag, "_digit"}, int'(countdown), 3 - j / 4);
      idle(1);
    end
    check_eq({tag, "_active"}, int'(race_active), 1);
    check_eq({tag, "_cd0"}, int'(countdown), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(3);
    check_eq("reset_outs", all_outs(), 0);
    rst = 1'b0;
    idle(2);

    run_countdown("start_a");

    pos(300, 300);
    pos(410, 550);
    repeat (5) pos(415, 580);
    idle(2);
    check_eq("shortcut_laps", int'(lap_count), 0);

    pos(410, 150);
    pos(300, 300);
    expect_pulse("lap1", K_LAP, cyc + 1);
    pos(410, 550);
    check_eq("lap1_count", int'(lap_count), 1);
    idle(2);

    expect_pulse("pause_stop", K_STOP, cyc + 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
    check_eq("paused_inactive", int'(race_active), 0);
    pos(410, 150);
    pos(300, 300);
    pos(410, 550);
    check_eq("paused_laps", int'(lap_count), 1);
    expect_pulse("resume_start", K_START, cyc + 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
    check_eq("resumed_active", int'(race_active), 1);
    pos(300, 300);
    pos(410, 550);
    idle(1);
    check_eq("resume_no_cp_laps", int'(lap_count), 1);

    pos(410, 150);
    pos(300, 300);
    expect_pulse("lap2", K_LAP, cyc + 1);
    expect_pulse("final_stop", K_STOP, cyc + 2);
    pos(410, 550);
    check_eq("lap2_count", int'(lap_count), 2);
    idle(1);
    check_eq("done_flag", int'(race_done), 1);
    check_eq("done_inactive", int'(race_active), 0);
    pos(410, 150);
    pos(300, 300);
    pos(410, 550);
    idle(2);
    check_eq("done_laps_hold", int'(lap_count), 2);

    run_countdown("start_b");
    check_eq("restart_laps", int'(lap_count), 0);
    check_eq("restart_done", int'(race_done), 0);
    pos(410, 150);
    pos(300, 300);
    expect_pulse("lap_b", K_LAP, cyc + 1);
    pos(410, 550);
    pos(410, 150);
    pos(300, 300);
    expect_pulse("abort_stop", K_STOP, cyc + 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 11'd410, 11'd550);
    check_eq("abort_laps_hold", int'(lap_count), 1);
    check_eq("abort_inactive", int'(race_active), 0);
    idle(3);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    idle(4);
    check_eq("rst_pre_cd", int'(countdown), 2);
    rst = 1'b1;
    idle(1);
    check_eq("rst_mid_outs", all_outs(), 0);
    rst = 1'b0;
    idle(20);
    check_eq("rst_stays_idle", int'(race_active), 0);

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
